rr_decoder_arbiter: RTL and testbench
=====================================

Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter sharing one 3-to-8 one-hot decode resource among 8 requesters.
- Selects one requester, drives its 3-bit index plus a decoder enable, and holds the grant until release or timeout.
- `grant` is the one-hot decode of `grant_idx` gated by `grant_valid`.
- Sits between requesting blocks and the shared select/decode path.

Parameters:
- MAX_HOLD, 16, max cycles a grant may be held before forced release; 0 disables timeout.
- CNT_W, 5, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  arbiter enable; gates new grants only.
- req  input  8  request vector, req[i] from requester i.
- release  input  1  asserted by current owner to end its grant.
- grant  output  8  one-hot grant, registered.
- grant_idx  output  3  binary index of the owner, registered.
- grant_valid  output  1  grant active; doubles as decoder enable.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset: one clock, synchronous, active-high; sampled on rising clk.
  - Reset values: grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
  - Reset has priority over all other inputs.
  - Reset during GRANT clears the grant at that same edge; no timeout pulse.
- State IDLE:
  - If en=1 and req!=0: pick the first i with req[i]=1, searching ptr, ptr+1, ..., ptr+7 (mod 8, wrap 7->0).
  - At that edge: grant_idx<=i, grant<=1<<i, grant_valid<=1, hold_cnt<=0, go to GRANT.
  - Latency: request sampled at edge k gives grant visible after edge k (one cycle).
  - If en=0 or req==0: stay in IDLE, outputs 0 (grant_idx keeps last value).
- State GRANT: end condition E = release | ~req[grant_idx] | (MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1).
  - On E: grant<=0, grant_valid<=0, ptr<=grant_idx+1 (mod 8), go to IDLE.
  - timeout<=1 only if the timeout term alone caused E (release=0 and req[grant_idx]=1).
  - Otherwise hold_cnt<=hold_cnt+1 and grant stays stable.
- Dead cycle: after any release, at least one cycle with grant_valid=0 before the next grant; no back-to-back handover.
- en=0 during GRANT: no preemption; the current grant runs to normal end, then no new grant while en=0.
- Requests from non-owners during GRANT are ignored; they compete at the next IDLE arbitration.
- release while in IDLE: ignored.
- Invariants, checked every cycle:
  - grant is one-hot or zero.
  - grant == (grant_valid ? 1<<grant_idx : 0).
  - timeout is never high for more than one consecutive cycle.
- Fairness: a requester held high continuously gets a grant within 8 grant periods.

Test Plan:
- Reset then single request: rst 2 cycles, req=8'h08, en=1 -> grant=8'h08, grant_idx=3 one cycle later; release at cycle 5 -> grant=0 next cycle, ptr=4.
- Round-robin wrap: req=8'h81 held, release after 2 cycles each grant -> grant sequence 8'h01, 8'h80, 8'h01, 8'h80, with one idle cycle between each.
- Timeout: MAX_HOLD=4, req=8'h02 held, release=0 -> grant high exactly 4 cycles, timeout pulses 1 cycle with grant drop; next grant to idx 1 again after one idle cycle (only requester).
- Request withdrawal: grant to idx 5, then req[5] drops -> grant=0 next edge, timeout=0, ptr=6.
- en gating: en=0 with req=8'hFF -> no grant; en dropped mid-grant -> grant persists until release, then stays 0 until en=1.
- Reset mid-grant: grant_idx=6 active, rst pulsed -> all outputs 0 next edge, ptr=0; with req=8'hC1 after reset -> first grant idx 0.

Source files
------------

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter
//   Round-robin arbiter that hands one shared 3-to-8 one-hot decode resource
//   to one of eight requesters at a time. The winner's index and decoder
//   enable are held until the owner releases, withdraws its request, or the
//   hold limit forces a release.
//
// Parameters
//   MAX_HOLD : cycles a grant may be held before forced release (0 = no limit)
//   CNT_W    : hold-counter width, 2**CNT_W must exceed MAX_HOLD
//
// Ports
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset
//   en            : arbiter enable, gates new grants only
//   req[7:0]      : request vector, req[i] from requester i
//   release_grant : current owner ends its grant
//   grant[7:0]    : registered one-hot grant
//   grant_idx     : registered binary index of the owner
//   grant_valid   : grant active, doubles as decoder enable
//   timeout       : one-cycle pulse on forced release
module rr_decoder_arbiter #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       release_grant,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_found;
    logic [2:0]       pick_idx;
    logic             owner_req;
    logic             hold_last;
    logic             end_grant;

    // First requester at or after ptr; the 3-bit index sum wraps 7 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (!pick_found && req[ptr_q + 3'(k)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_q + 3'(k);
            end
        end
    end

    always_comb begin
        owner_req = req[idx_q];
        hold_last = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
        end_grant = release_grant | ~owner_req | hold_last;
    end

    // State register (all flops)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en && pick_found) state_d = GRANT;
            GRANT:   if (end_grant)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        valid_d = valid_q;
        to_d    = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                valid_d = 1'b0;
                if (en && pick_found) begin
                    idx_d   = pick_idx;
                    grant_d = 8'b1 << pick_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (end_grant) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + 3'd1;
                    // Pulse only when the hold limit alone ended the grant.
                    to_d    = hold_last & ~release_grant & owner_req;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
module tb_rr_decoder_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst, en, rel;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid, timeout;

    int checks   = 0;
    int failures = 0;

    rr_decoder_arbiter #(.MAX_HOLD(MAXH), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .release_grant(rel),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic       rel;
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    // Reference model: owner (-1 = none), cycles the grant has been visible,
    // round-robin start point.
    int         m_owner = -1;
    int         m_held  = 0;
    int         m_ptr   = 0;
    logic [2:0] m_idx   = '0;
    logic       m_to    = 1'b0;
    logic       prev_to = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [7:0] q, input logic l,
                       input logic [7:0] g, input logic [2:0] i, input logic v, input logic t);
        vec_t x;
        x.rst = r; x.en = e; x.req = q; x.rel = l;
        x.g = g; x.idx = i; x.v = v; x.to = t;
        tbl.push_back(x);
    endtask

    task automatic model_update(input logic r, input logic e, input logic [7:0] q, input logic l);
        bit ends;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_idx = '0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            if (e && q != 0) begin
                for (int k = 0; k < 8; k++) begin
                    int j;
                    j = (m_ptr + k) % 8;
                    if (m_owner < 0 && q[j]) begin
                        m_owner = j; m_idx = 3'(j); m_held = 1;
                    end
                end
            end
        end else begin
            ends = l || !q[m_owner] || (MAXH != 0 && m_held == MAXH);
            m_to = ends && !l && q[m_owner];
            if (ends) begin
                m_ptr = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [7:0] q, input logic l);
        logic [7:0] dec;
        rst = r; en = e; req = q; rel = l;
        @(posedge clk);
        model_update(r, e, q, l);
        #1;
        dec = grant_valid ? (8'b1 << grant_idx) : 8'h00;
        chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
        chk("inv_decode", 32'(grant), 32'(dec));
        chk("inv_timeout_pulse", 32'(timeout && prev_to), 32'd0);
        prev_to = timeout;
    endtask

    initial begin
        logic [7:0] rq;
        logic [7:0] mg;
        rst = 1'b1; en = 1'b0; req = '0; rel = 1'b0;

        //  rst en req   rel   grant idx v to
        // reset, single request, release -> ptr 4
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h08, 0, 8'h08, 3, 1, 0);
        add(0, 1, 8'h08, 0, 8'h08, 3, 1, 0);
        add(0, 1, 8'h08, 1, 8'h00, 3, 0, 0);
        add(0, 1, 8'h18, 0, 8'h10, 4, 1, 0);
        add(0, 1, 8'h18, 1, 8'h00, 4, 0, 0);
        // round-robin wrap 0 <-> 7
        add(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h81, 0, 8'h01, 0, 1, 0);
        add(0, 1, 8'h81, 0, 8'h01, 0, 1, 0);
        add(0, 1, 8'h81, 1, 8'h00, 0, 0, 0);
        add(0, 1, 8'h81, 0, 8'h80, 7, 1, 0);
        add(0, 1, 8'h81, 0, 8'h80, 7, 1, 0);
        add(0, 1, 8'h81, 1, 8'h00, 7, 0, 0);
        add(0, 1, 8'h81, 0, 8'h01, 0, 1, 0);
        add(0, 1, 8'h81, 0, 8'h01, 0, 1, 0);
        add(0, 1, 8'h81, 1, 8'h00, 0, 0, 0);
        add(0, 1, 8'h81, 0, 8'h80, 7, 1, 0);
        add(0, 1, 8'h81, 0, 8'h80, 7, 1, 0);
        add(0, 1, 8'h81, 1, 8'h00, 7, 0, 0);
        // timeout after exactly MAXH visible cycles, then regrant
        add(0, 1, 8'h02, 0, 8'h02, 1, 1, 0);
        add(0, 1, 8'h02, 0, 8'h02, 1, 1, 0);
        add(0, 1, 8'h02, 0, 8'h02, 1, 1, 0);
        add(0, 1, 8'h02, 0, 8'h02, 1, 1, 0);
        add(0, 1, 8'h02, 0, 8'h00, 1, 0, 1);
        add(0, 1, 8'h02, 0, 8'h02, 1, 1, 0);
        add(0, 1, 8'h02, 1, 8'h00, 1, 0, 0);
        // withdrawal of request 5 -> ptr 6
        add(0, 1, 8'h20, 0, 8'h20, 5, 1, 0);
        add(0, 1, 8'h00, 0, 8'h00, 5, 0, 0);
        add(0, 1, 8'h60, 0, 8'h40, 6, 1, 0);
        // reset mid-grant, then first grant to idx 0
        add(1, 1, 8'h60, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'hC1, 0, 8'h01, 0, 1, 0);
        add(0, 1, 8'hC1, 1, 8'h00, 0, 0, 0);
        // en gating
        add(0, 0, 8'hFF, 0, 8'h00, 0, 0, 0);
        add(0, 0, 8'hFF, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'hFF, 0, 8'h02, 1, 1, 0);
        add(0, 0, 8'hFF, 0, 8'h02, 1, 1, 0);
        add(0, 0, 8'hFF, 1, 8'h00, 1, 0, 0);
        add(0, 0, 8'hFF, 0, 8'h00, 1, 0, 0);
        add(0, 1, 8'hFF, 0, 8'h04, 2, 1, 0);
        add(0, 1, 8'hFF, 1, 8'h00, 2, 0, 0);
        // release in IDLE ignored
        add(0, 0, 8'h00, 1, 8'h00, 2, 0, 0);

        for (int n = 0; n < tbl.size(); n++) begin
            step(tbl[n].rst, tbl[n].en, tbl[n].req, tbl[n].rel);
            chk($sformatf("vec%0d", n),
                {20'd0, grant, grant_idx, grant_valid, timeout},
                {20'd0, tbl[n].g, tbl[n].idx, tbl[n].v, tbl[n].to});
        end

        // Randomized phase against the model
        step(1, 0, 8'h00, 0);
        rq = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) rq = 8'($urandom) & 8'($urandom);
            step($urandom_range(99) == 0, $urandom_range(6) != 0, rq, $urandom_range(7) == 0);
            mg = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
            chk("rnd_grant", 32'(grant), 32'(mg));
            chk("rnd_idx", 32'(grant_idx), 32'(m_idx));
            chk("rnd_valid", 32'(grant_valid), 32'(m_owner >= 0));
            chk("rnd_timeout", 32'(timeout), 32'(m_to));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
